// File: rtl/full_adder_pkg.sv
// rtl/full_adder_pkg.sv - bit-level helper functions shared by the adder cells
package full_adder_pkg;

    function automatic logic xor3(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Carry is the majority of the three inputs.
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (b & c) | (a & c);
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// rtl/full_adder_cell.sv - 1-bit combinational full adder cell
module full_adder_cell
    import full_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic s,
    output logic c_out
);

    assign s     = xor3(a, b, c_in);
    assign c_out = maj3(a, b, c_in);

endmodule

// File: rtl/full_adder.sv
// rtl/full_adder.sv - WIDTH-bit ripple-carry adder with optional output register
module full_adder #(
    parameter int WIDTH      = 1,
    parameter bit OUTPUT_REG = 1'b1
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic [WIDTH-1:0] Data_A_In,
    input  logic [WIDTH-1:0] Data_B_In,
    input  logic             Carry_In,
    output logic             Carry_Out,
    output logic [WIDTH-1:0] Sum_Out
);

    localparam int SUM_W = WIDTH + 1;

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_comb;
    logic [SUM_W-1:0] result;

    assign carry[0] = Carry_In;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_cell u_cell (
            .a     (Data_A_In[i]),
            .b     (Data_B_In[i]),
            .c_in  (carry[i]),
            .s     (sum_comb[i]),
            .c_out (carry[i+1])
        );
    end

    assign result = {carry[WIDTH], sum_comb};

    if (OUTPUT_REG) begin : g_reg
        logic [SUM_W-1:0] result_q;

        // Reset wins over the sampled inputs, discarding any in-flight result.
        always_ff @(posedge Clk_In) begin
            if (Reset_In) begin
                result_q <= '0;
            end else begin
                result_q <= result;
            end
        end

        assign {Carry_Out, Sum_Out} = result_q;
    end else begin : g_comb
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, Clk_In, Reset_In};

        assign {Carry_Out, Sum_Out} = result;
    end

endmodule

// File: tb/tb_full_adder.sv
// tb/tb_full_adder.sv - scoreboard bench for registered 1/8-bit and combinational adders
module tb_full_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic       a1 = 1'b0, b1 = 1'b0, ci1 = 1'b0;
    logic       s1, co1;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0;
    logic [7:0] s8;
    logic       co8;
    logic [7:0] ac = '0, bc = '0;
    logic       cic = 1'b0;
    logic [7:0] sc;
    logic       coc;

    full_adder #(.WIDTH(1), .OUTPUT_REG(1'b1)) dut_w1 (
        .Clk_In(clk), .Reset_In(rst), .Data_A_In(a1), .Data_B_In(b1),
        .Carry_In(ci1), .Carry_Out(co1), .Sum_Out(s1)
    );

    full_adder #(.WIDTH(8), .OUTPUT_REG(1'b1)) dut_w8 (
        .Clk_In(clk), .Reset_In(rst), .Data_A_In(a8), .Data_B_In(b8),
        .Carry_In(ci8), .Carry_Out(co8), .Sum_Out(s8)
    );

    full_adder #(.WIDTH(8), .OUTPUT_REG(1'b0)) dut_comb (
        .Clk_In(1'b0), .Reset_In(1'b0), .Data_A_In(ac), .Data_B_In(bc),
        .Carry_In(cic), .Carry_Out(coc), .Sum_Out(sc)
    );

    typedef struct {
        logic [1:0] e1;
        logic [8:0] e8;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus for both registered adders; expectation from plain integer addition.
    task automatic step(input bit r, input logic x1, input logic y1, input logic z1,
                        input logic [7:0] x8, input logic [7:0] y8, input logic z8);
        exp_t e;
        int   s;
        @(negedge clk);
        #1;
        rst = r; a1 = x1; b1 = y1; ci1 = z1; a8 = x8; b8 = y8; ci8 = z8;
        if (r) begin
            e.e1 = '0;
            e.e8 = '0;
        end else begin
            s    = int'(x1) + int'(y1) + int'(z1);
            e.e1 = s[1:0];
            s    = int'(x8) + int'(y8) + int'(z8);
            e.e8 = s[8:0];
        end
        q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                check("w1_result", {30'b0, co1, s1}, {30'b0, e.e1});
                check("w8_result", {23'b0, co8, s8}, {23'b0, e.e8});
            end
        end
    end

    initial begin
        int s;
        logic [2:0] v;

        // Combinational variant: no clock involved.
        ac = 8'd1; bc = 8'd0; cic = 1'b1;
        #1;
        check("comb_101", {23'b0, coc, sc}, 32'h2);
        ac = 8'hFF; bc = 8'hFF; cic = 1'b1;
        #1;
        check("comb_ff_ff_1", {23'b0, coc, sc}, 32'h1FF);
        for (int i = 0; i < 8; i++) begin
            ac = 8'($urandom); bc = 8'($urandom); cic = 1'($urandom);
            #1;
            s = int'(ac) + int'(bc) + int'(cic);
            check("comb_rand", {23'b0, coc, sc}, 32'(s));
        end

        step(1'b1, 0, 0, 0, 8'h00, 8'h00, 0);
        step(1'b1, 0, 0, 0, 8'h00, 8'h00, 0);

        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            step(1'b0, v[2], v[1], v[0], 8'h00, 8'h00, 0);
        end

        for (int i = 0; i < 20; i++)
            step(1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));

        // Reset held for two edges over 111 inputs, then released.
        step(1'b1, 1, 1, 1, 8'hFF, 8'hFF, 1);
        step(1'b1, 1, 1, 1, 8'hFF, 8'hFF, 1);
        step(1'b0, 1, 1, 1, 8'hFF, 8'hFF, 1);

        // Latency: outputs must still show the 000 result until the next edge.
        step(1'b0, 0, 0, 0, 8'h00, 8'h00, 0);
        step(1'b0, 1, 1, 1, 8'hFF, 8'hFF, 1);
        check("latency_hold_w1", {30'b0, co1, s1}, 32'h0);
        check("latency_hold_w8", {23'b0, co8, s8}, 32'h0);

        // Full-width ripple boundaries.
        step(1'b0, 0, 0, 0, 8'hFF, 8'h00, 1);
        step(1'b0, 0, 0, 0, 8'hFF, 8'hFF, 1);
        step(1'b0, 0, 0, 0, 8'h00, 8'h00, 0);

        // Mid-stream reset discards the pending result.
        step(1'b0, 1, 0, 1, 8'hA5, 8'h5A, 1);
        step(1'b1, 1, 1, 0, 8'h80, 8'h80, 0);
        step(1'b0, 0, 1, 1, 8'h12, 8'h34, 1);

        repeat (4) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d results pending, expected 0", q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
